// File: rtl/unary_xnor_sched_pkg.sv
// ============================================================================
//  unary_xnor_sched_pkg
//  Shared state encoding and width helper for the XNOR parity scheduler.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package unary_xnor_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic int id_width(input int r);
    return $clog2(r);
  endfunction

endpackage

`default_nettype wire

// File: rtl/unary_xnor_scheduler_rr_arbiter.sv
// ============================================================================
//  rr_arbiter
//  Combinational round-robin search: first requester at or after ptr.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arbiter
  import unary_xnor_sched_pkg::*;
#(
  parameter int R = 4,
  localparam int IW = id_width(R)
) (
  input  logic [R-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  localparam logic [IW:0] C_R = (IW + 1)'(R);

  logic          w_found;
  logic [IW:0]   w_sum;
  logic [IW-1:0] w_idx;

  // Walk R positions from ptr, wrapping modulo R; the first hit wins.
  always_comb begin
    gnt_idx = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 0; k < R; k++) begin
      w_sum = {1'b0, ptr} + (IW + 1)'(k);
      if (w_sum >= C_R) begin
        w_sum = w_sum - C_R;
      end
      w_idx = w_sum[IW-1:0];
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        gnt_idx = w_idx;
      end
    end
  end

  assign any = |req;

endmodule

`default_nettype wire

// File: rtl/unary_xnor_scheduler.sv
// ============================================================================
//  unary_xnor_scheduler
//  Time-shares one reduction-XNOR datapath among R message requesters.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module unary_xnor_scheduler
  import unary_xnor_sched_pkg::*;
#(
  parameter int N = 8,
  parameter int R = 4,
  localparam int IW = id_width(R)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [R-1:0]    req_valid,
  input  logic [R-1:0]    req_last,
  input  logic [R*N-1:0]  req_data,
  output logic [R-1:0]    req_ready,
  output logic            rsp_valid,
  output logic [IW-1:0]   rsp_id,
  output logic            rsp_result,
  input  logic            rsp_ready
);

  localparam logic [IW-1:0] C_LAST_ID = IW'(R - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] gnt_q, gnt_d;
  logic [IW-1:0] rsp_id_q, rsp_id_d;
  logic          acc_q, acc_d;
  logic          rsp_result_q, rsp_result_d;

  logic [IW-1:0] arb_idx;
  logic          arb_any;
  logic [N-1:0]  word;
  logic          word_par;

  rr_arbiter #(
    .R(R)
  ) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  always_comb begin
    word = '0;
    for (int i = 0; i < R; i++) begin
      if (gnt_q == IW'(i)) begin
        word = req_data[i*N +: N];
      end
    end
  end

  assign word_par = ^word;

  // Handshake outputs depend only on registered state; inputs steer next state.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    gnt_d        = gnt_q;
    acc_d        = acc_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    req_ready    = '0;
    rsp_valid    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          gnt_d   = arb_idx;
          acc_d   = 1'b0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        req_ready[gnt_q] = 1'b1;
        if (req_valid[gnt_q]) begin
          acc_d = acc_q ^ word_par;
          if (req_last[gnt_q]) begin
            rsp_result_d = ~(acc_q ^ word_par);
            rsp_id_d     = gnt_q;
            state_d      = RESP;
          end
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          ptr_d   = (gnt_q == C_LAST_ID) ? '0 : gnt_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      gnt_q        <= '0;
      acc_q        <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      gnt_q        <= gnt_d;
      acc_q        <= acc_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
    end
  end

  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;

endmodule

`default_nettype wire
